// File: rtl/pixel_cfg_pkg.sv
// Shared types and default constants for the pixel column configuration sequencer.
package pixel_cfg_pkg;

   localparam int unsigned DEFAULT_N_COLS      = 64;
   localparam int unsigned DEFAULT_ACK_TIMEOUT = 255;
   localparam int unsigned DEFAULT_CFG_W       = 6;
   localparam int unsigned TIMER_W             = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SETUP,
      PUSH,
      WAIT_ACK,
      NEXT,
      DONE,
      ERR
   } cfg_state_e;

endpackage

// File: rtl/pixel_cfg_sequencer_ack_timer.sv
// Column acknowledge timer: cleared before each strobe, counts while waiting,
// flags the last permitted wait cycle.
module ack_timer
   import pixel_cfg_pkg::*;
#(
   parameter int unsigned LIMIT = DEFAULT_ACK_TIMEOUT
)(
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [TIMER_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Terminal count is the cycle whose increment brings the count to LIMIT.
   assign tc_o = en_i && (count_q == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/pixel_cfg_sequencer.sv
// Loads one configuration word per pixel column with a push/acknowledge
// handshake, reporting completion or acknowledge timeout.
module pixel_cfg_sequencer
   import pixel_cfg_pkg::*;
#(
   parameter  int unsigned N_COLS      = DEFAULT_N_COLS,
   parameter  int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
   parameter  int unsigned CFG_W       = DEFAULT_CFG_W,
   localparam int unsigned SEL_W       = (N_COLS > 1) ? $clog2(N_COLS) : 1
)(
   input  logic             spi_clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic             cfg_abort,
   input  logic             src_valid,
   input  logic [CFG_W-1:0] src_data,
   output logic             src_ready,
   output logic [CFG_W-1:0] col_data,
   output logic [SEL_W-1:0] col_sel,
   output logic             col_push,
   input  logic             col_ack,
   output logic             config_do,
   output logic             busy,
   output logic             err_timeout
);

   cfg_state_e       state_q, state_d;
   logic [CFG_W-1:0] data_q, data_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             err_q, err_d;
   logic             push_q, done_q, ready_q, busy_q;
   logic             tmr_clr, tmr_en, tmr_tc;

   ack_timer #(
      .LIMIT(ACK_TIMEOUT)
   ) u_ack_timer (
      .clk_i(spi_clk),
      .rst_i(rst),
      .clr_i(tmr_clr),
      .en_i (tmr_en),
      .tc_o (tmr_tc)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      err_d   = err_q;
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;
      if (cfg_abort && (state_q != IDLE)) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (cfg_start && !cfg_abort) begin
                  sel_d   = '0;
                  err_d   = 1'b0;
                  state_d = FETCH;
               end
            end
            FETCH: begin
               if (src_valid) begin
                  data_d  = src_data;
                  state_d = SETUP;
               end
            end
            SETUP: state_d = PUSH;
            PUSH: begin
               tmr_clr = 1'b1;
               state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
               tmr_en = 1'b1;
               // Acknowledge wins over a coincident terminal count.
               if (col_ack) begin
                  state_d = NEXT;
               end else if (tmr_tc) begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end
            end
            NEXT: begin
               if (sel_q == SEL_W'(N_COLS - 1)) begin
                  state_d = DONE;
               end else begin
                  sel_d   = sel_q + 1'b1;
                  state_d = FETCH;
               end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Strobes and status are registered from the next state so each one is
   // high exactly while the FSM sits in the corresponding state.
   always_ff @(posedge spi_clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         sel_q   <= '0;
         err_q   <= 1'b0;
         push_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
         push_q  <= (state_d == PUSH);
         done_q  <= (state_d == DONE);
         ready_q <= (state_d == FETCH);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign src_ready   = ready_q;
   assign col_data    = data_q;
   assign col_sel     = sel_q;
   assign col_push    = push_q;
   assign config_do   = done_q;
   assign busy        = busy_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_pixel_cfg_sequencer.sv
// Self-checking bench: a per-pass procedural timeline model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pixel_cfg_sequencer;

   localparam int NC = 4;
   localparam int TO = 5;
   localparam int W  = 6;

   logic         clk;
   logic         rst, cfg_start, cfg_abort, src_valid, col_ack;
   logic [W-1:0] src_data;
   logic         src_ready, col_push, config_do, busy, err_timeout;
   logic [W-1:0] col_data;
   logic [1:0]   col_sel;

   pixel_cfg_sequencer #(
      .N_COLS     (NC),
      .ACK_TIMEOUT(TO),
      .CFG_W      (W)
   ) dut (
      .spi_clk    (clk),
      .rst        (rst),
      .cfg_start  (cfg_start),
      .cfg_abort  (cfg_abort),
      .src_valid  (src_valid),
      .src_data   (src_data),
      .src_ready  (src_ready),
      .col_data   (col_data),
      .col_sel    (col_sel),
      .col_push   (col_push),
      .col_ack    (col_ack),
      .config_do  (config_do),
      .busy       (busy),
      .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   // ---------------- model: one pass as a timeline of edges ----------------
   int e_sel = 0, e_data = 0;
   bit e_ready = 0, e_push = 0, e_do = 0, e_busy = 0, e_err = 0;

   task automatic m_idle_outs();
      e_busy = 0; e_ready = 0; e_push = 0; e_do = 0;
   endtask

   task automatic m_edge(output bit ok);
      @(posedge clk);
      ok = 1'b0;
      if (rst) begin
         m_idle_outs();
         e_err = 0; e_sel = 0; e_data = 0;
      end else if (cfg_abort) begin
         m_idle_outs();
      end else begin
         ok = 1'b1;
      end
   endtask

   task automatic m_pass();
      bit ok;
      int waited;
      for (int c = 0; c < NC; c++) begin
         e_sel = c; e_ready = 1; e_busy = 1;
         do begin
            m_edge(ok);
            if (!ok) return;
         end while (!src_valid);
         e_data = int'(src_data); e_ready = 0;
         m_edge(ok);
         if (!ok) return;
         e_push = 1;
         m_edge(ok);
         if (!ok) return;
         e_push = 0;
         waited = 0;
         forever begin
            m_edge(ok);
            if (!ok) return;
            if (col_ack) break;
            waited++;
            if (waited == TO) begin
               e_err = 1;
               m_edge(ok);
               if (ok) m_idle_outs();
               return;
            end
         end
         m_edge(ok);
         if (!ok) return;
      end
      e_do = 1;
      m_edge(ok);
      if (ok) m_idle_outs();
   endtask

   initial begin : model
      forever begin
         @(posedge clk);
         if (rst) begin
            m_idle_outs();
            e_err = 0; e_sel = 0; e_data = 0;
         end else if (cfg_start && !cfg_abort) begin
            e_err = 0;
            m_pass();
         end
      end
   end

   // ---------------- stimulus state ----------------
   int src_idx = 0, src_base = 1, stall_col = -1, stall_left = 0;
   bit src_en = 1, prev_ready = 0, prev_err = 0, ack_force = 0;
   int ack_delay = 1, ack_cnt = -1;
   int log_sel[16], log_data[16], log_cyc[16];
   int log_n = 0, do_cnt = 0, do_cyc = -1, err_cyc = -1;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // One clock cycle: compare, monitor, then drive source and acknowledge.
   task automatic step();
      bit stalled;
      @(negedge clk);
      cyc++;
      if (chk_en) begin
         check("cyc_src_ready", int'(src_ready), int'(e_ready));
         check("cyc_col_push", int'(col_push), int'(e_push));
         check("cyc_config_do", int'(config_do), int'(e_do));
         check("cyc_busy", int'(busy), int'(e_busy));
         check("cyc_err_timeout", int'(err_timeout), int'(e_err));
         check("cyc_col_sel", int'(col_sel), e_sel);
         check("cyc_col_data", int'(col_data), e_data);
      end
      if (col_push && log_n < 16) begin
         log_sel[log_n]  = int'(col_sel);
         log_data[log_n] = int'(col_data);
         log_cyc[log_n]  = cyc;
         log_n++;
      end
      if (config_do) begin
         do_cnt++;
         do_cyc = cyc;
      end
      if (err_timeout && !prev_err) err_cyc = cyc;
      prev_err = err_timeout;
      if (prev_ready && src_valid && !cfg_abort && !rst) src_idx++;
      stalled = (src_idx == stall_col) && src_ready && (stall_left > 0);
      if (stalled) stall_left--;
      src_valid  = src_en && !stalled;
      src_data   = W'(src_base + src_idx);
      prev_ready = src_ready;
      if (col_push) ack_cnt = 0;
      else if (ack_cnt >= 0 && ack_cnt < 1000) ack_cnt++;
      col_ack = ack_force || (ack_delay > 0 && ack_cnt == ack_delay);
   endtask

   task automatic clear_log();
      log_n = 0; do_cnt = 0; do_cyc = -1; err_cyc = -1; src_idx = 0;
   endtask

   task automatic start_pass();
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int n = 0;
      while (busy && n < budget) begin
         step();
         n++;
      end
      if (busy) check(nm, 1, 0);
   endtask

   task automatic wait_push(input int cnt, input int budget, input string nm);
      int n = 0;
      while (log_n < cnt && n < budget) begin
         step();
         n++;
      end
      if (log_n < cnt) check(nm, log_n, cnt);
   endtask

   initial begin : main
      rst = 1; cfg_start = 0; cfg_abort = 0; src_valid = 0; src_data = '0; col_ack = 0;
      chk_en = 1'b1;
      step();
      check("rst_busy", int'(busy), 0);
      check("rst_src_ready", int'(src_ready), 0);
      check("rst_col_sel", int'(col_sel), 0);
      check("rst_col_data", int'(col_data), 0);
      check("rst_err", int'(err_timeout), 0);
      step();
      rst = 0;
      step(); step();

      // Nominal pass: words 1..4, ack in first wait cycle.
      clear_log(); src_base = 1; ack_delay = 1;
      start_pass();
      wait_idle(200, "nom_busy_timeout");
      check("nom_push_count", log_n, 4);
      for (int i = 0; i < 4; i++) begin
         check("nom_sel", log_sel[i], i);
         check("nom_data", log_data[i], i + 1);
      end
      check("nom_do_count", do_cnt, 1);
      check("nom_push_spacing", log_cyc[1] - log_cyc[0], 5);
      check("nom_do_latency", do_cyc - log_cyc[3], 3);
      check("nom_err", int'(err_timeout), 0);
      step(); step();

      // Source stall of 10 cycles in column 2.
      clear_log(); src_base = 'h10; stall_col = 2; stall_left = 10;
      start_pass();
      wait_idle(300, "stall_busy_timeout");
      stall_col = -1;
      check("stall_push_count", log_n, 4);
      check("stall_spacing", log_cyc[2] - log_cyc[1], 15);
      check("stall_data2", log_data[2], 'h12);
      check("stall_do_count", do_cnt, 1);
      check("stall_err", int'(err_timeout), 0);
      step(); step();

      // Acknowledge timeout.
      clear_log(); ack_delay = 0;
      start_pass();
      wait_idle(100, "to_busy_timeout");
      check("to_push_count", log_n, 1);
      check("to_err_delay", err_cyc - log_cyc[0], 6);
      check("to_err", int'(err_timeout), 1);
      check("to_do_count", do_cnt, 0);
      step(); step();

      // Next start clears the error; ack on terminal-count cycle wins.
      clear_log(); ack_delay = TO; src_base = 'h20;
      start_pass();
      check("tc_err_cleared", int'(err_timeout), 0);
      wait_idle(300, "tc_busy_timeout");
      check("tc_push_count", log_n, 4);
      check("tc_spacing", log_cyc[1] - log_cyc[0], 9);
      check("tc_do_count", do_cnt, 1);
      check("tc_err", int'(err_timeout), 0);
      step(); step();

      // Abort in WAIT_ACK of column 1 (coincident ack loses).
      clear_log(); ack_delay = 1; src_base = 'h30;
      start_pass();
      wait_push(2, 100, "ab_push_timeout");
      step();
      cfg_abort = 1;
      step();
      cfg_abort = 0;
      check("ab_busy", int'(busy), 0);
      check("ab_sel_hold", int'(col_sel), 1);
      check("ab_data_hold", int'(col_data), 'h31);
      step(); step();
      check("ab_do_count", do_cnt, 0);
      clear_log();
      start_pass();
      wait_idle(200, "ab_restart_timeout");
      check("ab_restart_sel0", log_sel[0], 0);
      check("ab_restart_count", log_n, 4);
      check("ab_restart_do", do_cnt, 1);
      step();

      // Abort in FETCH with a valid word: word not consumed, data held.
      clear_log(); src_base = 'h05;
      start_pass();
      cfg_abort = 1;
      step();
      cfg_abort = 0;
      check("abf_busy", int'(busy), 0);
      check("abf_data_hold", int'(col_data), 'h33);
      // Start and abort together in IDLE.
      cfg_start = 1; cfg_abort = 1;
      step();
      cfg_start = 0; cfg_abort = 0;
      check("sa_busy", int'(busy), 0);
      step();

      // Start while busy ignored; reset in PUSH; ack in IDLE ignored.
      clear_log(); ack_delay = 1; src_base = 'h3A;
      start_pass();
      cfg_start = 1;
      step();
      cfg_start = 0;
      wait_push(1, 50, "rp_push_timeout");
      rst = 1;
      step();
      rst = 0;
      check("rp_busy", int'(busy), 0);
      check("rp_push", int'(col_push), 0);
      check("rp_sel", int'(col_sel), 0);
      check("rp_data", int'(col_data), 0);
      check("rp_ready", int'(src_ready), 0);
      check("rp_do", int'(config_do), 0);
      ack_force = 1;
      step(); step(); step();
      ack_force = 0;
      step();
      check("rp_idle_busy", int'(busy), 0);
      check("rp_no_more_push", log_n, 1);
      check("rp_no_do", do_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
